// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default width and the parity helper
// that the transmitter uses as well.
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StParity,
        StStop,
        StBreak
    } uart_rx_state_t;

    // Even parity bit: makes the data bits plus this bit contain an even number of ones.
    function automatic logic even_parity(input logic [DEFAULT_DATA_WIDTH-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// Single-clock UART receiver: one line bit per clk, start, LSB-first data, optional even
// parity, stop. A frame ending on a low stop bit parks in StBreak until the line goes high.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic                  parity,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    uart_rx_state_t        state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  par_en;
    logic                  par_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            shreg      <= '0;
            bit_cnt    <= '0;
            par_en     <= 1'b0;
            par_bit    <= 1'b0;
            rx_data    <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!rx) begin
                        par_en  <= parity;
                        bit_cnt <= CNT_W'(DATA_WIDTH);
                        busy    <= 1'b1;
                        state   <= StData;
                    end
                end
                StData: begin
                    shreg   <= {rx, shreg[DATA_WIDTH-1:1]};
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    if (bit_cnt == CNT_W'(1)) begin
                        state <= par_en ? StParity : StStop;
                    end
                end
                StParity: begin
                    par_bit <= rx;
                    state   <= StStop;
                end
                StStop: begin
                    rx_data    <= shreg;
                    parity_err <= par_en & (^shreg ^ par_bit);
                    frame_err  <= ~rx;
                    valid      <= 1'b1;
                    if (rx) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        state <= StBreak;
                    end
                end
                StBreak: begin
                    // Held-low line: no start detection until it returns high.
                    if (rx) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames, checked
// against a frame-level model of the expected word, flags, timing and busy behaviour.
module tb_uart_rx;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx = 1'b1;
    logic         parity = 1'b0;
    logic [W-1:0] rx_data;
    logic         valid;
    logic         parity_err;
    logic         frame_err;
    logic         busy;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_valid_cyc = 0;
    logic valid_prev = 1'b0;

    uart_rx #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .parity     (parity),
        .rx_data    (rx_data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // valid must never be high on two consecutive cycles.
    always @(negedge clk) begin
        if (!rst) check("valid_single_cycle", 32'(valid & valid_prev), 32'd0);
        valid_prev = valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: parity bit that makes the frame's ones count even.
    function automatic logic ref_par_bit(input logic [W-1:0] d);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += int'(d[i]);
        return (ones % 2) != 0;
    endfunction

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin
            step();
            check("idle_no_valid", 32'(valid), 32'd0);
        end
    endtask

    // Drives one frame; pe is the parity setting present at the start bit.
    task automatic send_frame(input logic [W-1:0] d, input logic pe, input logic bad_par,
                              input logic stop, input logic flip_par);
        int start_cyc;
        parity = pe;
        rx = 1'b0;
        start_cyc = cyc;
        step();
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < int'(W); i++) begin
            rx = d[i];
            if (flip_par && i == 3) parity = ~parity;
            step();
            check("no_valid_in_data", 32'(valid), 32'd0);
        end
        if (pe) begin
            rx = ref_par_bit(d) ^ bad_par;
            step();
            check("no_valid_in_parity", 32'(valid), 32'd0);
        end
        rx = stop;
        step();
        check("valid_at_latency", 32'(valid), 32'd1);
        check("latency", 32'(cyc - start_cyc), pe ? W + 3 : W + 2);
        check("rx_data", 32'(rx_data), 32'(d));
        check("parity_err", 32'(parity_err), 32'(pe & bad_par));
        check("frame_err", 32'(frame_err), 32'(!stop));
        check("busy_after_stop", 32'(busy), 32'(!stop));
        last_valid_cyc = cyc;
    endtask

    initial begin
        int prev_valid;
        logic [W-1:0] d;
        logic pe, bp, sb;

        // Reset state
        repeat (3) step();
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle(2);

        // Plain frame, parity good, parity bad
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        check("busy_idle", 32'(busy), 32'd0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1);

        // Low stop bit followed by a held-low line
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (5) begin
            step();
            check("break_no_valid", 32'(valid), 32'd0);
            check("break_busy", 32'(busy), 32'd1);
            check("break_data_held", 32'(rx_data), 32'h3C);
        end
        rx = 1'b1;
        check("break_busy_before_high", 32'(busy), 32'd1);
        step();
        check("break_busy_drop", 32'(busy), 32'd0);
        check("break_frame_err_held", 32'(frame_err), 32'd1);
        idle(12);
        check("break_no_restart", 32'(busy), 32'd0);

        // Back-to-back frames with no idle gap
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        prev_valid = last_valid_cyc;
        send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
        check("b2b_spacing", 32'(last_valid_cyc - prev_valid), 32'd10);
        idle(2);

        // Reset during data bit 4
        d = 8'h96;
        parity = 1'b0;
        rx = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            step();
        end
        rx = d[4];
        rst = 1'b1;
        step();
        check("midrst_rx_data", 32'(rx_data), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_parity_err", 32'(parity_err), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle(12);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // parity toggled mid-frame: latched 0 wins
        send_frame(8'h6B, 1'b0, 1'b0, 1'b1, 1'b1);
        parity = 1'b0;
        idle(2);

        // Randomized frames
        for (int n = 0; n < 24; n++) begin
            d  = W'($urandom);
            pe = 1'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 4) != 0);
            send_frame(d, pe, bp, sb, 1'($urandom));
            if (!sb) begin
                rx = 1'b1;
                step();
                check("rand_break_exit", 32'(busy), 32'd0);
            end
            idle($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
